pla_cube_eval_seq: RTL and testbench

- Programmable, sequential successor to the fixed single-output PLA/AIG benchmark functions in the autosymmetry suite.
- Holds DEPTH cubes over N_IN inputs with an N_OUT output plane, and evaluates one input vector per transaction, LANES cubes per cycle.
- Supports sum-of-products (OR plane) and exclusive-sum-of-products (XOR plane) modes.
- Sits behind a valid/ready stream. Used to check synthesized netlists against their PLA source in hardware.

---
 rtl/pla_cube_eval_seq.sv | 127 ++++++++++++
 tb/tb_pla_cube_eval_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pla_cube_eval_seq.sv
// Programmable PLA cube evaluator behind a valid/ready stream.
// DEPTH cubes over N_IN inputs feed an N_OUT output plane. Each accepted
// input vector is folded through every cube slot, LANES slots per cycle.
// The fold is OR (sum of products) or XOR (exclusive sum of products).
module pla_cube_eval_seq #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 1,
    parameter int DEPTH = 16,
    parameter int LANES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    output logic                     cfg_ready,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [N_IN-1:0]          cfg_care,
    input  logic [N_IN-1:0]          cfg_val,
    input  logic [N_OUT-1:0]         cfg_out,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT-1:0]         out_y,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    state_t           state;
    logic [N_IN-1:0]  care_mem [DEPTH];
    logic [N_IN-1:0]  val_mem  [DEPTH];
    logic [N_OUT-1:0] out_mem  [DEPTH];

    logic [AW-1:0]    idx;
    logic [N_IN-1:0]  x_reg;
    logic             mode_reg;
    logic [N_OUT-1:0] acc;
    logic [N_OUT-1:0] grp;
    logic [N_OUT-1:0] acc_next;
    logic             last_group;

    // Cube storage: cleared on reset, written only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            care_mem <= '{default: '0};
            val_mem  <= '{default: '0};
            out_mem  <= '{default: '0};
        end else if (cfg_we && state == IDLE) begin
            care_mem[cfg_addr] <= cfg_care;
            val_mem[cfg_addr]  <= cfg_val;
            out_mem[cfg_addr]  <= cfg_out;
        end
    end

    // Match the current group of LANES slots and fold them with the active operator.
    always_comb begin
        grp = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (((x_reg ^ val_mem[idx + AW'(l)]) & care_mem[idx + AW'(l)]) == '0) begin
                grp = mode_reg ? (grp ^ out_mem[idx + AW'(l)])
                               : (grp | out_mem[idx + AW'(l)]);
            end
        end
        acc_next   = mode_reg ? (acc ^ grp) : (acc | grp);
        last_group = (idx == AW'(DEPTH - LANES));
    end

    // Transaction FSM with all handshake and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            x_reg     <= '0;
            mode_reg  <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= in_x;
                        mode_reg  <= mode;
                        acc       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                        cfg_ready <= 1'b0;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    acc <= acc_next;
                    // idx is always a multiple of LANES, so the add wraps exactly at DEPTH
                    idx <= idx + AW'(LANES);
                    if (last_group) begin
                        out_y     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pla_cube_eval_seq.sv
// Directed testbench for pla_cube_eval_seq: a default LANES=1 instance plus
// a LANES=4 instance sharing clock, reset and configuration inputs.
module tb_pla_cube_eval_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_care = '0;
    logic [7:0] cfg_val = '0;
    logic [0:0] cfg_out = '0;
    logic       mode = 1'b0;
    logic [7:0] in_x = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_valid4 = 1'b0;
    logic       out_ready4 = 1'b1;

    logic       cfg_ready, in_ready, out_valid, busy;
    logic [0:0] out_y;
    logic       cfg_ready4, in_ready4, out_valid4, busy4;
    logic [0:0] out_y4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pla_cube_eval_seq #(.N_IN(8), .N_OUT(1), .DEPTH(16), .LANES(1)) u1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
    );

    pla_cube_eval_seq #(.N_IN(8), .N_OUT(1), .DEPTH(16), .LANES(4)) u4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ready(cfg_ready4),
        .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out),
        .mode(mode), .in_valid(in_valid4), .in_ready(in_ready4), .in_x(in_x),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_y(out_y4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] c, input logic [7:0] v,
                             input logic o);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_care = c; cfg_val = v; cfg_out = o;
        @(negedge clk);
        cfg_we = 1'b0; cfg_addr = 'x; cfg_care = 'x; cfg_val = 'x; cfg_out = 'x;
    endtask

    // Presents one vector; returns at the negedge just after the accept edge.
    task automatic start_txn(input bit sel, input logic [7:0] x, input logic m);
        @(negedge clk);
        check(sel ? "in_ready4_pre" : "in_ready_pre", sel ? in_ready4 : in_ready, 1);
        in_x = x; mode = m;
        if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_valid4 = 1'b0; in_x = 'x;
    endtask

    // Counts edges until out_valid (bounded), then checks latency and result.
    task automatic wait_result(input bit sel, input int exp_lat, input logic exp_y, input string tag);
        int n = 0;
        while (!(sel ? out_valid4 : out_valid) && n < 200) begin
            check({tag, "_busy"}, sel ? busy4 : busy, 1);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_y"}, sel ? out_y4 : out_y, exp_y);
        check({tag, "_in_ready_done"}, sel ? in_ready4 : in_ready, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready4", in_ready4, 1);

        // Empty memory: result 0 after exactly 16 cycles
        start_txn(0, 8'hA5, 1'b0);
        wait_result(0, 16, 1'b0, "empty_A5");

        // Single fully specified cube
        cfg_write(4'd0, 8'hFF, 8'h3C, 1'b1);
        start_txn(0, 8'h3C, 1'b0);
        wait_result(0, 16, 1'b1, "full_3C");
        start_txn(0, 8'h3D, 1'b0);
        wait_result(0, 16, 1'b0, "full_3D");

        // Two single-literal cubes, SOP vs ESOP
        cfg_write(4'd0, 8'h01, 8'h01, 1'b1);
        cfg_write(4'd5, 8'h02, 8'h02, 1'b1);
        start_txn(0, 8'h03, 1'b1);
        wait_result(0, 16, 1'b0, "esop_03");
        start_txn(0, 8'h03, 1'b0);
        wait_result(0, 16, 1'b1, "sop_03");
        start_txn(0, 8'h01, 1'b1);
        wait_result(0, 16, 1'b1, "esop_01");

        // Same vectors on the LANES=4 instance
        start_txn(1, 8'h03, 1'b1);
        wait_result(1, 4, 1'b0, "l4_esop_03");
        start_txn(1, 8'h03, 1'b0);
        wait_result(1, 4, 1'b1, "l4_sop_03");
        start_txn(1, 8'h01, 1'b1);
        wait_result(1, 4, 1'b1, "l4_esop_01");

        // Back-pressure in DONE
        out_ready = 1'b0;
        start_txn(0, 8'h03, 1'b0);
        wait_result(0, 16, 1'b1, "hold");
        repeat (5) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_y", out_y, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_cfg_ready", cfg_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_out_y_held", out_y, 1);

        // Write during EVAL is dropped
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        start_txn(0, 8'h00, 1'b0);
        check("drop_cfg_ready", cfg_ready, 0);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_care = 8'hFF; cfg_val = 8'h00; cfg_out = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        // one EVAL edge has already passed since accept
        wait_result(0, 15, 1'b0, "drop_txn");
        start_txn(0, 8'h00, 1'b0);
        wait_result(0, 16, 1'b0, "drop_next");

        // Reset mid-EVAL aborts and clears memory
        cfg_write(4'd0, 8'hFF, 8'h3C, 1'b1);
        start_txn(0, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        start_txn(0, 8'h3C, 1'b0);
        wait_result(0, 16, 1'b0, "midrst_cleared");

        // Write to the last slot in the accept cycle is visible to that transaction
        @(negedge clk);
        in_x = 8'h3C; mode = 1'b0; in_valid = 1'b1;
        cfg_we = 1'b1; cfg_addr = 4'd15; cfg_care = 8'hFF; cfg_val = 8'h3C; cfg_out = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0; in_x = 'x;
        wait_result(0, 16, 1'b1, "same_cycle_slot15");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
